// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
//   Writeback arbiter for the integer register file's single write port
//   (we3/a3/wd3). In-pipeline writeback results always win the port.
//   Long-latency results (divider, multi-cycle ops) wait in a small in-order
//   FIFO and drain whenever the pipeline does not write.
//   A pending-destination scoreboard tells the hazard unit which registers
//   still wait for a long-latency result. A starvation counter requests a
//   writeback bubble when buffered results are blocked for too long.
//
// Handshake: a long-latency result transfers on a rising clock edge where
//   lv_valid && lv_ready. lv_ready depends only on registered state, and the
//   producer holds lv_rd/lv_wd stable while lv_valid is high and not accepted.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   pipe_we/rd/wd         W-stage writeback (never back-pressured)
//   lv_valid/rd/wd        long-latency result in; lv_ready is accept
//   issue_valid/issue_rd  long-latency op issued; marks rd pending
//   rs1, rs2              D-stage sources; rs1_busy/rs2_busy are the hazards
//   wb_stall_req          registered request for a pipeline writeback bubble
//   we3, a3, wd3          register file write port
// -----------------------------------------------------------------------------
module wb_arbiter #(
   parameter int XLEN         = 32,
   parameter int E_SUPPORTED  = 0,
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            pipe_we,
   input  logic [4:0]      pipe_rd,
   input  logic [XLEN-1:0] pipe_wd,
   input  logic            lv_valid,
   input  logic [4:0]      lv_rd,
   input  logic [XLEN-1:0] lv_wd,
   output logic            lv_ready,
   input  logic            issue_valid,
   input  logic [4:0]      issue_rd,
   input  logic [4:0]      rs1,
   input  logic [4:0]      rs2,
   output logic            rs1_busy,
   output logic            rs2_busy,
   output logic            wb_stall_req,
   output logic            we3,
   output logic [4:0]      a3,
   output logic [XLEN-1:0] wd3
);

   localparam int NUMREGS = (E_SUPPORTED != 0) ? 16 : 32;
   localparam int RI      = (E_SUPPORTED != 0) ? 4 : 5;
   localparam int PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW      = $clog2(DEPTH + 1);
   localparam int SW      = $clog2(STARVE_LIMIT + 1);

   // ---------------------------------------------------------------- state
   logic [4:0]         fifo_rd_q [DEPTH];
   logic [4:0]         fifo_rd_d [DEPTH];
   logic [XLEN-1:0]    fifo_wd_q [DEPTH];
   logic [XLEN-1:0]    fifo_wd_d [DEPTH];
   logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]      count_q, count_d;
   logic [NUMREGS-1:0] pending_q, pending_d;
   logic [SW-1:0]      starve_q, starve_d;
   logic               stall_q, stall_d;

   // ---------------------------------------------------------------- decode
   logic          pipe_wr;    // pipeline write to a real register
   logic          fifo_ne;
   logic          pop;
   logic          push;
   logic [4:0]    head_rd;
   logic [XLEN-1:0] head_wd;
   logic [RI-1:0] head_idx, issue_idx, rs1_idx, rs2_idx;

   assign pipe_wr  = pipe_we && (pipe_rd != 5'd0);
   assign fifo_ne  = (count_q != '0);
   assign head_rd  = fifo_rd_q[rd_ptr_q];
   assign head_wd  = fifo_wd_q[rd_ptr_q];
   assign head_idx  = head_rd[RI-1:0];
   assign issue_idx = issue_rd[RI-1:0];
   assign rs1_idx   = rs1[RI-1:0];
   assign rs2_idx   = rs2[RI-1:0];

   assign lv_ready = !reset && (count_q < CW'(DEPTH));
   // lv_rd==0 results are accepted but dropped: x0 is never written.
   assign push     = lv_valid && lv_ready && (lv_rd != 5'd0);
   assign pop      = !reset && !pipe_wr && fifo_ne;

   // ---------------------------------------------------------------- write port
   always_comb begin
      we3 = !reset && (pipe_wr || fifo_ne);
      a3  = 5'd0;
      wd3 = '0;
      if (pipe_wr) begin
         a3  = pipe_rd;
         wd3 = pipe_wd;
      end else if (fifo_ne) begin
         a3  = head_rd;
         wd3 = head_wd;
      end
   end

   // ---------------------------------------------------------------- hazards
   // The regfile writes on the falling edge, so a draining value is already
   // readable in the same cycle and does not count as busy.
   assign rs1_busy = (rs1 != 5'd0) && pending_q[rs1_idx] && !(pop && (head_idx == rs1_idx));
   assign rs2_busy = (rs2 != 5'd0) && pending_q[rs2_idx] && !(pop && (head_idx == rs2_idx));
   assign wb_stall_req = stall_q;

   // ---------------------------------------------------------------- next state
   always_comb begin
      fifo_rd_d = fifo_rd_q;
      fifo_wd_d = fifo_wd_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      pending_d = pending_q;
      starve_d  = starve_q;
      stall_d   = stall_q;

      if (push) begin
         fifo_rd_d[wr_ptr_q] = lv_rd;
         fifo_wd_d[wr_ptr_q] = lv_wd;
         wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      // Push while full cannot happen (ready is low), so no overflow case.
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      // Clear before set so a same-cycle issue to the draining rd stays pending.
      if (pop) pending_d[head_idx] = 1'b0;
      if (issue_valid && (issue_idx != '0)) pending_d[issue_idx] = 1'b1;
      pending_d[0] = 1'b0;

      // Blocked cycles: buffered result waiting while the pipeline owns the port.
      // The counter saturates at the limit; only a pop releases the stall.
      if (pop) begin
         starve_d = '0;
      end else if (fifo_ne && pipe_wr && (starve_q != SW'(STARVE_LIMIT))) begin
         starve_d = starve_q + 1'b1;
      end
      stall_d = !pop && (stall_q || (starve_d == SW'(STARVE_LIMIT)));
   end

   // ---------------------------------------------------------------- flops
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         pending_q <= '0;
         starve_q  <= '0;
         stall_q   <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         pending_q <= pending_d;
         starve_q  <= starve_d;
         stall_q   <= stall_d;
      end
   end

   // Payload storage needs no reset: it is only read while count_q says valid.
   always_ff @(posedge clk) begin
      fifo_rd_q <= fifo_rd_d;
      fifo_wd_q <= fifo_wd_d;
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
//   Directed scenarios followed by randomized traffic. A behavioural model
//   (result queue, pending array, blocked-cycle count) predicts every output
//   each cycle; directed scenarios add explicit constant expectations.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;

   localparam int XLEN  = 32;
   localparam int DEPTH = 2;
   localparam int LIMIT = 4;

   // ---------------------------------------------------------------- clock/reset
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic            pipe_we;
   logic [4:0]      pipe_rd;
   logic [XLEN-1:0] pipe_wd;
   logic            lv_valid;
   logic [4:0]      lv_rd;
   logic [XLEN-1:0] lv_wd;
   logic            lv_ready;
   logic            issue_valid;
   logic [4:0]      issue_rd;
   logic [4:0]      rs1, rs2;
   logic            rs1_busy, rs2_busy;
   logic            wb_stall_req;
   logic            we3;
   logic [4:0]      a3;
   logic [XLEN-1:0] wd3;

   wb_arbiter #(.XLEN(XLEN), .E_SUPPORTED(0), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .reset(reset),
      .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_wd(pipe_wd),
      .lv_valid(lv_valid), .lv_rd(lv_rd), .lv_wd(lv_wd), .lv_ready(lv_ready),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
      .wb_stall_req(wb_stall_req), .we3(we3), .a3(a3), .wd3(wd3)
   );

   // ---------------------------------------------------------------- scoreboard
   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: buffered results in arrival order, {rd, wd}.
   logic [36:0] exp_q[$];
   bit          m_pend[32];
   int          m_blocked;
   bit          m_stall;

   function automatic bit model_busy(input logic [4:0] rs, input bit drain);
      if (rs == 5'd0 || !m_pend[rs]) return 1'b0;
      if (drain && exp_q[0][36:32] == rs) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_check();
      bit pw, drain, exp_we;
      pw     = pipe_we && (pipe_rd != 5'd0);
      drain  = !reset && !pw && (exp_q.size() > 0);
      exp_we = !reset && (pw || exp_q.size() > 0);
      chk("we3", we3, exp_we);
      if (exp_we) begin
         chk("a3", a3, pw ? pipe_rd : exp_q[0][36:32]);
         chk("wd3", wd3, pw ? pipe_wd : exp_q[0][31:0]);
      end
      chk("x0_write", we3 && (a3 == 5'd0), 1'b0);
      chk("lv_ready", lv_ready, !reset && (exp_q.size() < DEPTH));
      chk("rs1_busy", rs1_busy, model_busy(rs1, drain));
      chk("rs2_busy", rs2_busy, model_busy(rs2, drain));
      chk("wb_stall_req", wb_stall_req, m_stall);
   endtask

   task automatic model_update();
      bit pw, ready;
      logic [36:0] h;
      if (reset) begin
         exp_q.delete();
         foreach (m_pend[i]) m_pend[i] = 1'b0;
         m_blocked = 0;
         m_stall   = 1'b0;
         return;
      end
      pw    = pipe_we && (pipe_rd != 5'd0);
      ready = exp_q.size() < DEPTH;
      if (!pw && exp_q.size() > 0) begin
         h = exp_q.pop_front();
         m_pend[h[36:32]] = 1'b0;
         m_blocked = 0;
         m_stall   = 1'b0;
      end else if (pw && exp_q.size() > 0) begin
         m_blocked++;
         if (m_blocked >= LIMIT) m_stall = 1'b1;
      end
      if (lv_valid && ready && lv_rd != 5'd0) exp_q.push_back({lv_rd, lv_wd});
      if (issue_valid && issue_rd != 5'd0) m_pend[issue_rd] = 1'b1;
   endtask

   // ---------------------------------------------------------------- driver
   task automatic idle();
      pipe_we = 0; pipe_rd = 0; pipe_wd = 0;
      lv_valid = 0; lv_rd = 0; lv_wd = 0;
      issue_valid = 0; issue_rd = 0; rs1 = 0; rs2 = 0;
   endtask

   // Inputs are set just after a rising edge; checks run mid-cycle.
   task automatic step();
      #2;
      model_check();
      model_update();
      @(posedge clk);
      #1;
   endtask

   // ---------------------------------------------------------------- stimulus
   int bias;

   initial begin
      idle();
      reset = 1'b1;
      m_blocked = 0;
      m_stall = 1'b0;
      @(posedge clk); #1;
      step(); step();
      reset = 1'b0;

      // Reset with two buffered results and x5 pending.
      issue_valid = 1; issue_rd = 5;
      pipe_we = 1; pipe_rd = 1; pipe_wd = 32'h1;
      lv_valid = 1; lv_rd = 2; lv_wd = 32'h2;
      step();
      issue_valid = 0; lv_rd = 3; lv_wd = 32'h3;
      step();
      idle(); reset = 1'b1; #1;
      chk("rst_we3", we3, 1'b0);
      chk("rst_ready", lv_ready, 1'b0);
      step();
      reset = 1'b0; rs1 = 5; #1;
      chk("post_rst_we3", we3, 1'b0);
      chk("post_rst_ready", lv_ready, 1'b1);
      chk("post_rst_busy", rs1_busy, 1'b0);
      step();

      // Issue x7, result arrives later, drains next cycle.
      idle(); issue_valid = 1; issue_rd = 7; step();
      idle(); step(); step(); step();
      lv_valid = 1; lv_rd = 7; lv_wd = 32'hDEAD_BEEF; rs1 = 7; #1;
      chk("x7_busy_wait", rs1_busy, 1'b1);
      step();
      idle(); rs1 = 7; #1;
      chk("x7_we3", we3, 1'b1);
      chk("x7_a3", a3, 5'd7);
      chk("x7_wd3", wd3, 32'hDEAD_BEEF);
      chk("x7_busy_drain", rs1_busy, 1'b0);
      step();
      rs1 = 7; #1;
      chk("x7_busy_after", rs1_busy, 1'b0);
      step();

      // Collision: lv accepted, then pipeline writes first.
      idle(); lv_valid = 1; lv_rd = 3; lv_wd = 32'h11; step();
      idle(); pipe_we = 1; pipe_rd = 4; pipe_wd = 32'h22; #1;
      chk("col_a3_pipe", a3, 5'd4);
      chk("col_wd3_pipe", wd3, 32'h22);
      step();
      idle(); #1;
      chk("col_a3_lv", a3, 5'd3);
      chk("col_wd3_lv", wd3, 32'h11);
      step();

      // Fill and starve.
      idle(); pipe_we = 1; pipe_rd = 1; pipe_wd = 32'hAA;
      lv_valid = 1; lv_rd = 10; lv_wd = 32'hA0; step();
      lv_rd = 11; lv_wd = 32'hB0; step();
      lv_rd = 12; lv_wd = 32'hC0; #1;
      chk("full_ready", lv_ready, 1'b0);
      step(); step();
      lv_valid = 0; #1;
      chk("stall_early", wb_stall_req, 1'b0);
      step(); #1;
      chk("stall_up", wb_stall_req, 1'b1);
      pipe_we = 0; #1;
      chk("starve_drain_a3", a3, 5'd10);
      step(); #1;
      chk("stall_down", wb_stall_req, 1'b0);
      step();

      // x0 handling.
      idle(); pipe_we = 1; pipe_rd = 0; pipe_wd = 32'h55;
      lv_valid = 1; lv_rd = 0; lv_wd = 32'h66; #1;
      chk("x0_we3", we3, 1'b0);
      step();
      idle(); #1;
      chk("x0_no_push", we3, 1'b0);
      step();

      // Same-cycle issue and drain of x9: set wins.
      idle(); lv_valid = 1; lv_rd = 9; lv_wd = 32'h99; step();
      idle(); issue_valid = 1; issue_rd = 9; step();
      idle(); rs2 = 9; #1;
      chk("x9_busy", rs2_busy, 1'b1);
      step();

      // Randomized traffic.
      bias = 50;
      for (int c = 0; c < 3000; c++) begin
         if (c % 50 == 0) bias = $urandom_range(10, 95);
         reset       = ($urandom_range(0, 99) == 0);
         pipe_we     = ($urandom_range(0, 99) < bias);
         if (m_stall && $urandom_range(0, 3) != 0) pipe_we = 1'b0;
         pipe_rd     = 5'($urandom_range(0, 31));
         pipe_wd     = $urandom;
         lv_valid    = ($urandom_range(0, 1) == 1);
         lv_rd       = 5'($urandom_range(0, 31));
         lv_wd       = $urandom;
         issue_valid = ($urandom_range(0, 2) == 0);
         issue_rd    = 5'($urandom_range(0, 31));
         rs1         = 5'($urandom_range(0, 31));
         rs2         = 5'($urandom_range(0, 31));
         step();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
